// File: rtl/nla_pkg.sv
// Shared definitions for the numeric datapath stages.
//   state_e      : Horner evaluation FSM states
//   DEF_DATA_W   : default sample/coefficient width
//   DEF_FRAC_W   : default number of fractional bits
//   SAT_MAX/MIN  : saturation bounds for the default width
//   SAT_IN_W     : width of the wide intermediate handed to saturate()
//   saturate()   : clamps a wide signed value to a w-bit signed range
package nla_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;

    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 16'sh8000;

    localparam int SAT_IN_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_TOP,
        S_LD_TOP,
        S_MUL_START,
        S_MUL_WAIT,
        S_ADD,
        S_DONE
    } state_e;

    // Result stays in the wide format so callers can compare it with the
    // input to detect clipping, then truncate to w bits.
    function automatic logic signed [SAT_IN_W-1:0] saturate(
        input logic signed [SAT_IN_W-1:0] v,
        input int                         w
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/seq_mult_shift_add.sv
// Iterative signed multiplier, radix-2 shift-add, one multiplier bit per clock.
//   clk, rst : clock, synchronous active-high reset (aborts any product)
//   go       : one-cycle launch; a and b are sampled on this edge
//   a, b     : signed DATA_W-bit operands
//   done     : one-cycle strobe, DATA_W clock edges counting the launch edge
//   p        : signed 2*DATA_W-bit product, held until the next done
module seq_mult_shift_add #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   p
);

    localparam int PW = 2 * DATA_W;
    localparam int CW = $clog2(DATA_W + 1);

    logic              run_q;
    logic              done_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [PW-1:0]     p_q;

    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [PW-1:0]     cur_acc;
    logic [PW-1:0]     cur_mcand;
    logic [DATA_W-1:0] cur_mplier;
    logic [PW-1:0]     acc_nxt;
    logic              last;

    // Unsigned magnitudes: -(-2^(W-1)) wraps to 2^(W-1), which is exactly
    // right when the value is read back as unsigned.
    always_comb begin
        mag_a = a[DATA_W-1] ? -a : a;
        mag_b = b[DATA_W-1] ? -b : b;
    end

    // The launch edge already consumes the first multiplier bit, so the
    // whole product takes DATA_W edges including the launch.
    always_comb begin
        if (go) begin
            cur_acc    = '0;
            cur_mcand  = {{DATA_W{1'b0}}, mag_a};
            cur_mplier = mag_b;
        end else begin
            cur_acc    = acc_q;
            cur_mcand  = mcand_q;
            cur_mplier = mplier_q;
        end
        acc_nxt = cur_acc + (cur_mplier[0] ? cur_mcand : '0);
        last    = run_q && (cnt_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (go) begin
                run_q    <= 1'b1;
                neg_q    <= a[DATA_W-1] ^ b[DATA_W-1];
                cnt_q    <= CW'(DATA_W - 1);
                acc_q    <= acc_nxt;
                mcand_q  <= cur_mcand << 1;
                mplier_q <= cur_mplier >> 1;
            end else if (run_q) begin
                cnt_q    <= cnt_q - CW'(1);
                acc_q    <= acc_nxt;
                mcand_q  <= cur_mcand << 1;
                mplier_q <= cur_mplier >> 1;
                if (last) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                    p_q    <= neg_q ? -acc_nxt : acc_nxt;
                end
            end
        end
    end

    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/horner_poly_datapath.sv
// Horner polynomial evaluator in signed Q(DATA_W-FRAC_W).FRAC_W fixed point:
// y = ((c_N*x + c_(N-1))*x + ...)*x + c0, coefficients streamed highest first.
//   clk, rst     : clock, synchronous active-high reset (discards evaluation)
//   start        : launch pulse, honoured only when idle
//   x_in         : sample x, latched on an accepted start
//   n_coeff      : degree N (N+1 coefficients), latched on an accepted start
//   coeff_rd_en  : one-cycle read strobe to the coefficient buffer
//   coeff_in     : coefficient data, valid the cycle after coeff_rd_en
//   busy         : high whenever the FSM is not idle
//   result_valid : one-cycle strobe, coincident with a new result
//   result       : registered result, held until the next result_valid
//   overflow     : sticky saturation flag for the current evaluation
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | waiting for start
// S_RD_TOP    | request the highest-order coefficient
// S_LD_TOP    | load it into the accumulator
// S_MUL_START | launch acc*x, request the next coefficient
// S_MUL_WAIT  | wait for the multiplier
// S_ADD       | acc <= sat(scaled product + coefficient)
// S_DONE      | publish the result
module horner_poly_datapath
    import nla_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int ADDR_LINES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     x_in,
    input  logic [ADDR_LINES-1:0] n_coeff,
    output logic                  coeff_rd_en,
    input  logic [DATA_W-1:0]     coeff_in,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_W-1:0]     result,
    output logic                  overflow
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     x_q, x_d;
    logic [ADDR_LINES-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_W-1:0]     c_q;
    logic                  rd_dly_q;

    logic                  mul_go;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_p;

    logic signed [SAT_IN_W-1:0] p_ext;
    logic signed [SAT_IN_W-1:0] prod_shift;
    logic signed [SAT_IN_W-1:0] prod_sat;
    logic signed [SAT_IN_W-1:0] c_ext;
    logic signed [SAT_IN_W-1:0] sum;
    logic                       prod_ovf;
    logic                       sum_ovf;
    logic [DATA_W-1:0]          acc_add;

    seq_mult_shift_add #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk  (clk),
        .rst  (rst),
        .go   (mul_go),
        .a    (acc_q),
        .b    (x_q),
        .done (mul_done),
        .p    (mul_p)
    );

    // Everything is widened to SAT_IN_W so the add cannot wrap before it
    // is clipped; the shift floors towards minus infinity.
    always_comb begin
        p_ext      = {{(SAT_IN_W-2*DATA_W){mul_p[2*DATA_W-1]}}, mul_p};
        prod_shift = p_ext >>> FRAC_W;
        prod_sat   = saturate(prod_shift, DATA_W);
        prod_ovf   = (prod_sat != prod_shift);
        c_ext      = {{(SAT_IN_W-DATA_W){c_q[DATA_W-1]}}, c_q};
        sum        = prod_sat + c_ext;
        sum_ovf    = (saturate(sum, DATA_W) != sum);
        acc_add    = DATA_W'(saturate(sum, DATA_W));
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        ovf_d       = ovf_q;
        mul_go      = 1'b0;
        coeff_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    cnt_d   = n_coeff;
                    ovf_d   = 1'b0;
                    state_d = S_RD_TOP;
                end
            end
            S_RD_TOP: begin
                coeff_rd_en = 1'b1;
                state_d     = S_LD_TOP;
            end
            S_LD_TOP: begin
                acc_d   = coeff_in;
                state_d = (cnt_q == '0) ? S_DONE : S_MUL_START;
            end
            S_MUL_START: begin
                mul_go      = 1'b1;
                coeff_rd_en = 1'b1;
                if (cnt_q != '0)
                    cnt_d = cnt_q - ADDR_LINES'(1);
                state_d     = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mul_done)
                    state_d = S_ADD;
            end
            S_ADD: begin
                acc_d = acc_add;
                if (prod_ovf || sum_ovf)
                    ovf_d = 1'b1;
                state_d = (cnt_q == '0) ? S_DONE : S_MUL_START;
            end
            S_DONE: begin
                result_d = acc_q;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            c_q      <= '0;
            rd_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            // Buffer data arrives one cycle after the strobe.
            rd_dly_q <= coeff_rd_en;
            if (rd_dly_q)
                c_q <= coeff_in;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_horner_poly_datapath.sv
module tb_horner_poly_datapath;
    import nla_pkg::*;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int AL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] x_in;
    logic [AL-1:0] n_coeff;
    logic          coeff_rd_en;
    logic [DW-1:0] coeff_in;
    logic          busy;
    logic          result_valid;
    logic [DW-1:0] result;
    logic          overflow;

    horner_poly_datapath #(
        .DATA_W     (DW),
        .FRAC_W     (FW),
        .ADDR_LINES (AL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x_in         (x_in),
        .n_coeff      (n_coeff),
        .coeff_rd_en  (coeff_rd_en),
        .coeff_in     (coeff_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
        int            lat;
        int            rds;
    } exp_t;

    typedef struct {
        logic [DW-1:0] x;
        int            n;
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
        logic [DW-1:0] c2;
        logic [DW-1:0] res;
        logic          ovf;
    } pcase_t;

    exp_t          sb_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            cycle_cnt   = 0;
    int            t0          = 0;
    int            rd_cnt      = 0;
    int            busy_cnt    = 0;
    int            ptr         = 0;
    logic [DW-1:0] coef_mem [16];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Coefficient buffer: answers a strobe with data valid the next cycle.
    always @(negedge clk) begin
        if (coeff_rd_en === 1'b1) begin
            coeff_in = coef_mem[ptr[3:0]];
            ptr      = ptr + 1;
            rd_cnt   = rd_cnt + 1;
        end
        if (busy === 1'b1)
            busy_cnt = busy_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1);
    end

    function automatic longint clamp(input longint v, inout logic o);
        if (v > longint'(SAT_MAX)) begin
            o = 1'b1;
            return longint'(SAT_MAX);
        end
        if (v < longint'(SAT_MIN)) begin
            o = 1'b1;
            return longint'(SAT_MIN);
        end
        return v;
    endfunction

    // Reference Horner evaluation with plain integer arithmetic.
    function automatic void model(input logic [DW-1:0] x, input int n,
                                  output logic [DW-1:0] r, output logic o);
        longint acc;
        longint pr;
        o   = 1'b0;
        acc = longint'($signed(coef_mem[0]));
        for (int i = 1; i <= n; i++) begin
            pr  = acc * longint'($signed(x));
            pr  = pr >>> FW;
            pr  = clamp(pr, o);
            pr  = pr + longint'($signed(coef_mem[i]));
            acc = clamp(pr, o);
        end
        r = acc[DW-1:0];
    endfunction

    task automatic launch(input logic [DW-1:0] x, input int n,
                          input logic [DW-1:0] er, input logic eo);
        exp_t e;
        @(negedge clk);
        ptr      = 0;
        rd_cnt   = 0;
        busy_cnt = 0;
        x_in     = x;
        n_coeff  = n[AL-1:0];
        start    = 1'b1;
        e.res = er;
        e.ovf = eo;
        e.lat = 3 + n * (DW + 2);
        e.rds = n + 1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        t0    = cycle_cnt;
    endtask

    task automatic wait_result(input int limit, output bit got, output logic [DW-1:0] r,
                               output logic o, output int lat);
        got = 1'b0;
        r   = 'x;
        o   = 1'bx;
        lat = -1;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1'b1;
                r   = result;
                o   = overflow;
                lat = cycle_cnt - t0;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        x_in    = '0;
        n_coeff = '0;
        coeff_in = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        vectors++;
        if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        vectors++;
        if (coeff_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b expected 0", coeff_rd_en); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plan_cases();
        pcase_t        tbl [6];
        exp_t          e;
        bit            got;
        logic [DW-1:0] r;
        logic          o;
        int            lat;
        tbl[0] = '{16'h0000, 0, 16'h0280, 16'h0000, 16'h0000, 16'h0280, 1'b0};
        tbl[1] = '{16'h0200, 2, 16'h0100, 16'hFD00, 16'h0200, 16'h0000, 1'b0};
        tbl[2] = '{16'hFF80, 1, 16'h0100, 16'h0000, 16'h0000, 16'hFF80, 1'b0};
        tbl[3] = '{16'h7F00, 1, 16'h7F00, 16'h7F00, 16'h0000, 16'h7FFF, 1'b1};
        tbl[4] = '{16'h1234, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0};
        tbl[5] = '{16'h8000, 1, 16'h0100, 16'h0000, 16'h0000, 16'h8000, 1'b0};
        for (int k = 0; k < 6; k++) begin
            coef_mem[0] = tbl[k].c0;
            coef_mem[1] = tbl[k].c1;
            coef_mem[2] = tbl[k].c2;
            launch(tbl[k].x, tbl[k].n, tbl[k].res, tbl[k].ovf);
            wait_result(200, got, r, o, lat);
            e = sb_q.pop_front();
            vectors++;
            if (r !== e.res) begin miscompares++; $display("FAIL plan%0d_result: got %h (seen %0b) expected %h", k, r, got, e.res); end
            vectors++;
            if (o !== e.ovf) begin miscompares++; $display("FAIL plan%0d_overflow: got %b expected %b", k, o, e.ovf); end
            vectors++;
            if (lat !== e.lat) begin miscompares++; $display("FAIL plan%0d_latency: got %0d expected %0d", k, lat, e.lat); end
            vectors++;
            if (rd_cnt !== e.rds) begin miscompares++; $display("FAIL plan%0d_reads: got %0d expected %0d", k, rd_cnt, e.rds); end
            vectors++;
            if (busy_cnt !== e.lat) begin miscompares++; $display("FAIL plan%0d_busy_cycles: got %0d expected %0d", k, busy_cnt, e.lat); end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t          e;
        bit            got;
        logic [DW-1:0] r;
        logic          o;
        int            lat;
        int            extra;
        coef_mem[0] = 16'h0100;
        coef_mem[1] = 16'h0080;
        coef_mem[2] = 16'h7777;
        launch(16'h0100, 1, 16'h0180, 1'b0);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        x_in    = 16'h7F00;
        n_coeff = 4'hF;
        @(negedge clk);
        start = 1'b0;
        wait_result(200, got, r, o, lat);
        e = sb_q.pop_front();
        vectors++;
        if (r !== e.res) begin miscompares++; $display("FAIL busy_ign_result: got %h (seen %0b) expected %h", r, got, e.res); end
        vectors++;
        if (lat !== e.lat) begin miscompares++; $display("FAIL busy_ign_latency: got %0d expected %0d", lat, e.lat); end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_valid === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin miscompares++; $display("FAIL busy_ign_extra_valid: got %0d expected 0", extra); end
        vectors++;
        if (rd_cnt !== e.rds) begin miscompares++; $display("FAIL busy_ign_reads: got %0d expected %0d", rd_cnt, e.rds); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_ign_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_abort();
        exp_t          e;
        bit            got;
        logic [DW-1:0] r;
        logic          o;
        int            lat;
        int            seen;
        coef_mem[0] = 16'h0100;
        coef_mem[1] = 16'hFD00;
        coef_mem[2] = 16'h0200;
        launch(16'h0200, 2, 16'h0000, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_front());
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
        vectors++;
        if (result !== 16'h0000) begin miscompares++; $display("FAIL abort_result: got %h expected 0000", result); end
        vectors++;
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b expected 0", result_valid); end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL abort_stray_valid: got %0d expected 0", seen); end
        coef_mem[0] = 16'h0100;
        coef_mem[1] = 16'h0000;
        launch(16'hFF80, 1, 16'hFF80, 1'b0);
        wait_result(200, got, r, o, lat);
        e = sb_q.pop_front();
        vectors++;
        if (r !== e.res) begin miscompares++; $display("FAIL abort_fresh_result: got %h (seen %0b) expected %h", r, got, e.res); end
        vectors++;
        if (lat !== e.lat) begin miscompares++; $display("FAIL abort_fresh_latency: got %0d expected %0d", lat, e.lat); end
    endtask

    task automatic test_random();
        exp_t          e;
        bit            got;
        logic [DW-1:0] r;
        logic          o;
        int            lat;
        int            n;
        logic [DW-1:0] x;
        logic [DW-1:0] er;
        logic          eo;
        for (int k = 0; k < 8; k++) begin
            n = (k == 7) ? 15 : int'($urandom_range(0, 4));
            if (k % 2 == 0)
                x = 16'($urandom_range(0, 511)) - 16'd256;
            else
                x = 16'($urandom_range(0, 65535));
            for (int i = 0; i < 16; i++)
                coef_mem[i] = (k % 3 == 0) ? 16'($urandom_range(0, 65535))
                                           : 16'($urandom_range(0, 4095)) - 16'd2048;
            model(x, n, er, eo);
            launch(x, n, er, eo);
            wait_result(400, got, r, o, lat);
            e = sb_q.pop_front();
            vectors++;
            if (r !== e.res) begin miscompares++; $display("FAIL rand%0d_result: got %h (seen %0b) expected %h x=%h n=%0d", k, r, got, e.res, x, n); end
            vectors++;
            if (o !== e.ovf) begin miscompares++; $display("FAIL rand%0d_overflow: got %b expected %b", k, o, e.ovf); end
            vectors++;
            if (lat !== e.lat) begin miscompares++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, e.lat); end
            vectors++;
            if (rd_cnt !== e.rds) begin miscompares++; $display("FAIL rand%0d_reads: got %0d expected %0d", k, rd_cnt, e.rds); end
        end
    endtask

    initial begin
        test_reset();
        test_plan_cases();
        test_busy_ignore();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
